// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial adder controller. Adds two WIDTH-bit operands plus
//               a carry-in one bit per clock through a single full-adder bit
//               cell, with a start/done handshake toward the requester.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH  : operand and result width in bits (>= 2)
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous, active-low reset
//   start  in   1      request, sampled only while idle
//   a      in   WIDTH  operand A, captured on the accepting edge
//   b      in   WIDTH  operand B, captured on the accepting edge
//   cin    in   1      carry-in, captured on the accepting edge
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse; sum/cout valid from this cycle on
//   sum    out  WIDTH  result word, held until the next completion
//   cout   out  1      final carry-out, held until the next completion
// ============================================================================
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q,  a_sr_d;
  logic [WIDTH-1:0] b_sr_q,  b_sr_d;
  logic [WIDTH-1:0] r_sr_q,  r_sr_d;
  logic             c_q,     c_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;

  // Full-adder bit cell fed from the shift-register LSBs and the carry flop.
  logic bit_a;
  logic bit_b;
  logic bit_s;
  logic bit_c;

  always_comb begin
    bit_a = a_sr_q[0];
    bit_b = b_sr_q[0];
    bit_s = bit_a ^ bit_b ^ c_q;
    bit_c = (bit_a & bit_b) | (bit_a & c_q) | (bit_b & c_q);
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath update
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    r_sr_d  = r_sr_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          c_d     = cin;
          cnt_d   = '0;
          r_sr_d  = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        c_d    = bit_c;
        a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
        r_sr_d = {bit_s, r_sr_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        // The last bit lands straight in the output register on the same
        // edge, so sum/cout never expose a partially built word.
        if (cnt_q == LAST_BIT) begin
          sum_d   = {bit_s, r_sr_q[WIDTH-1:1]};
          cout_d  = bit_c;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      r_sr_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      r_sr_q  <= r_sr_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // busy/done decode straight from the state flop: both drop to 0 the
  // instant reset is asserted, and done lasts exactly the one DONE cycle.
  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
    sum  = sum_q;
    cout = cout_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Self-checking bench for serial_adder_ctrl (WIDTH=8 directed
//               scenarios plus a WIDTH=4 exhaustive sweep).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst_n;

  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic       s4_start;
  logic [3:0] s4_a;
  logic [3:0] s4_b;
  logic       s4_cin;
  logic       s4_busy;
  logic       s4_done;
  logic [3:0] s4_sum;
  logic       s4_cout;

  int n_assert;
  int n_fail;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (s4_start),
    .a     (s4_a),
    .b     (s4_b),
    .cin   (s4_cin),
    .busy  (s4_busy),
    .done  (s4_done),
    .sum   (s4_sum),
    .cout  (s4_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
    s4_start = 1'b0; s4_a = 4'h0; s4_b = 4'h0; s4_cin = 1'b0;
    repeat (2) @(negedge clk);
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_assert++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_assert++; if (sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum got %h want 00", sum); end
    n_assert++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %b want 0", cout); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_vectors();
    logic [7:0] va [4] = '{8'h00, 8'hFF, 8'h5A, 8'hFF};
    logic [7:0] vb [4] = '{8'h00, 8'h01, 8'h3C, 8'hFF};
    logic       vc [4] = '{1'b0,  1'b0,  1'b1,  1'b1};
    logic [7:0] es [4] = '{8'h00, 8'h00, 8'h97, 8'hFF};
    logic       ec [4] = '{1'b0,  1'b1,  1'b0,  1'b1};
    int n;
    int busy_cnt;
    for (int i = 0; i < 4; i++) begin
      start = 1'b1; a = va[i]; b = vb[i]; cin = vc[i];
      @(negedge clk);
      start = 1'b0;
      n = 1;
      busy_cnt = 0;
      while (!done && n < 20) begin
        if (busy) busy_cnt++;
        @(negedge clk);
        n++;
      end
      n_assert++; if (n !== 9) begin n_fail++; $display("FAIL vec%0d_latency got %0d want 9", i, n); end
      n_assert++; if (busy_cnt !== 8) begin n_fail++; $display("FAIL vec%0d_busy_cycles got %0d want 8", i, busy_cnt); end
      n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL vec%0d_busy_in_done got %b want 0", i, busy); end
      n_assert++; if (sum !== es[i]) begin n_fail++; $display("FAIL vec%0d_sum got %h want %h", i, sum, es[i]); end
      n_assert++; if (cout !== ec[i]) begin n_fail++; $display("FAIL vec%0d_cout got %b want %b", i, cout, ec[i]); end
      @(negedge clk);
      n_assert++; if (done !== 1'b0) begin n_fail++; $display("FAIL vec%0d_done_pulse got %b want 0", i, done); end
      n_assert++; if (sum !== es[i]) begin n_fail++; $display("FAIL vec%0d_sum_hold got %h want %h", i, sum, es[i]); end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_start_held();
    int n;
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
    @(negedge clk);
    n = 1;
    while (!done && n < 20) begin
      a = 8'hC3 + 8'(n); b = 8'h7E - 8'(n); cin = 1'b1;
      @(negedge clk);
      n++;
    end
    n_assert++; if (n !== 9) begin n_fail++; $display("FAIL held_latency got %0d want 9", n); end
    n_assert++; if (sum !== 8'h46) begin n_fail++; $display("FAIL held_sum got %h want 46", sum); end
    n_assert++; if (cout !== 1'b0) begin n_fail++; $display("FAIL held_cout got %b want 0", cout); end
    // DONE cycle: start still high with junk operands, must be ignored.
    a = 8'hEE; b = 8'hEE; cin = 1'b1;
    @(negedge clk);
    n_assert++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL held_idle got busy=%b done=%b want 0/0", busy, done); end
    a = 8'h80; b = 8'h80; cin = 1'b1;
    @(negedge clk);
    n_assert++; if (busy !== 1'b1) begin n_fail++; $display("FAIL held_reaccept got busy=%b want 1", busy); end
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_assert++; if (n !== 9) begin n_fail++; $display("FAIL held2_latency got %0d want 9", n); end
    n_assert++; if (sum !== 8'h01 || cout !== 1'b1) begin n_fail++; $display("FAIL held2_result got %h/%b want 01/1", sum, cout); end
    @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_midrun();
    int n;
    int done_seen;
    start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);  // bits 0..2 processed, bit 3 next
    rst_n = 1'b0;
    #1;
    n_assert++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_flags got busy=%b done=%b want 0/0", busy, done); end
    n_assert++; if (sum !== 8'h00 || cout !== 1'b0) begin n_fail++; $display("FAIL midrst_result got %h/%b want 00/0", sum, cout); end
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    n_assert++; if (done_seen !== 0) begin n_fail++; $display("FAIL midrst_no_done got %0d pulses want 0", done_seen); end
    start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_assert++; if (n !== 9) begin n_fail++; $display("FAIL midrst_fresh_latency got %0d want 9", n); end
    n_assert++; if (sum !== 8'hFF || cout !== 1'b0) begin n_fail++; $display("FAIL midrst_fresh_result got %h/%b want FF/0", sum, cout); end
    @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_operand_change();
    int n;
    int unstable;
    start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    unstable = 0;
    while (!done && n < 20) begin
      if (sum !== 8'hFF || cout !== 1'b0) unstable++;
      a = 8'hF0 ^ 8'(n); b = 8'h0F ^ 8'(n * 3); cin = n[0];
      @(negedge clk);
      n++;
    end
    n_assert++; if (unstable !== 0) begin n_fail++; $display("FAIL chg_hold got %0d changed cycles want 0", unstable); end
    n_assert++; if (n !== 9) begin n_fail++; $display("FAIL chg_latency got %0d want 9", n); end
    n_assert++; if (sum !== 8'h02 || cout !== 1'b0) begin n_fail++; $display("FAIL chg_result got %h/%b want 02/0", sum, cout); end
    @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_exhaustive_w4();
    int n;
    logic [4:0] expv;
    for (int i = 0; i < 512; i++) begin
      s4_start = 1'b1;
      s4_a = 4'(i >> 5);
      s4_b = 4'(i >> 1);
      s4_cin = i[0];
      expv = 5'(i >> 5) + 5'((i >> 1) & 15) + 5'(i & 1);
      @(negedge clk);
      s4_start = 1'b0;
      n = 1;
      while (!s4_done && n < 12) begin
        @(negedge clk);
        n++;
      end
      n_assert++;
      if (n !== 5 || {s4_cout, s4_sum} !== expv) begin
        n_fail++;
        $display("FAIL w4_add a=%h b=%h cin=%b got %b%h lat=%0d want %b%h lat=5",
                 4'(i >> 5), 4'(i >> 1), i[0], s4_cout, s4_sum, n, expv[4], expv[3:0]);
      end
      @(negedge clk);
    end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    n_assert = 0;
    n_fail   = 0;
    test_reset();
    test_vectors();
    test_start_held();
    test_reset_midrun();
    test_operand_change();
    test_exhaustive_w4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
